// File: rtl/resp_signature.sv
// resp_signature: compacts a stream of DUT response beats into a 32-bit CRC-style signature.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, abort           begin a capture run (honoured in IDLE only) / cancel from any state
//   cfg_skip, cfg_cycles   leading beats to discard / beats to compact, both latched on start
//   resp_valid, resp_data  one response beat per qualified cycle
//   busy                   high whenever the FSM is not IDLE
//   res_valid, res_ready   result handshake; res_valid is high only in DONE
//   res_sig, res_count     live signature register and compacted-beat count
module resp_signature #(
  parameter int          OUT_W = 330,
  parameter int          CYC_W = 32,
  parameter logic [31:0] SEED  = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       cfg_skip,
  input  logic [CYC_W-1:0] cfg_cycles,
  input  logic             resp_valid,
  input  logic [OUT_W-1:0] resp_data,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_sig,
  output logic [CYC_W-1:0] res_count
);
  localparam int NW = (OUT_W + 31) / 32;
  localparam logic [1:0] IDLE = 2'd0, SKIP = 2'd1, RUN = 2'd2, DONE = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [31:0]      sig_q, sig_d, fold;
  logic [CYC_W-1:0] count_q, count_d, cycles_q, cycles_d, count_inc;
  logic [7:0]       skip_q, skip_d;
  logic [NW*32-1:0] padded;
  // Zero-extend to whole words, then XOR the words together.
  always_comb begin
    padded = '0;
    padded[OUT_W-1:0] = resp_data;
    fold = '0;
    for (int k = 0; k < NW; k++) fold = fold ^ padded[32*k +: 32];
  end
  assign count_inc = count_q + CYC_W'(1);
  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    count_d  = count_q;
    skip_d   = skip_q;
    cycles_d = cycles_q;
    if (abort) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (start) begin
          sig_d    = SEED;
          count_d  = '0;
          skip_d   = cfg_skip;
          cycles_d = cfg_cycles;
          state_d  = cfg_skip != 8'd0 ? SKIP : cfg_cycles != '0 ? RUN : DONE;
        end
        SKIP: if (resp_valid) begin
          skip_d = skip_q - 8'd1;
          if (skip_q == 8'd1) state_d = cycles_q != '0 ? RUN : DONE;
        end
        RUN: if (resp_valid) begin
          sig_d   = ({sig_q[30:0], 1'b0} ^ (sig_q[31] ? 32'h04C11DB7 : 32'h0)) ^ fold;
          count_d = count_inc;
          if (count_inc == cycles_q) state_d = DONE;
        end
        default: if (res_ready) state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sig_q    <= '0;
      count_q  <= '0;
      skip_q   <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      count_q  <= count_d;
      skip_q   <= skip_d;
      cycles_q <= cycles_d;
    end
  end
  assign busy      = state_q != IDLE;
  assign res_valid = state_q == DONE;
  assign res_sig   = sig_q;
  assign res_count = count_q;
endmodule

// File: tb/tb_resp_signature.sv
// tb_resp_signature: scoreboard bench for resp_signature with directed, hand-computed vectors.
module tb_resp_signature;
  logic         clk, rst_n, start, abort, resp_valid, res_ready;
  logic [7:0]   cfg_skip;
  logic [31:0]  cfg_cycles;
  logic [329:0] resp_data, d;
  logic         busy, res_valid;
  logic [31:0]  res_sig, res_count;
  int           checks = 0, failures = 0;
  logic [63:0]  exp_q[$];
  logic [63:0]  e;
  logic         seen = 1'b0;

  resp_signature dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_skip(cfg_skip), .cfg_cycles(cfg_cycles),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_sig(res_sig), .res_count(res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [7:0] s, input logic [31:0] c);
    cfg_skip = s;
    cfg_cycles = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [329:0] data, input logic ab);
    resp_valid = 1'b1;
    resp_data = data;
    abort = ab;
    tick();
    resp_valid = 1'b0;
    abort = 1'b0;
    resp_data = '0;
  endtask

  task automatic accept(input string name);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    @(negedge clk);
    chk({name, "_busy_after"}, 64'(busy), 64'd0);
    chk({name, "_valid_after"}, 64'(res_valid), 64'd0);
  endtask

  // Monitor: pops one expected result each time a result is presented.
  always @(negedge clk) begin
    if (!rst_n) seen = 1'b0;
    else if (res_valid && !seen) begin
      seen = 1'b1;
      if (exp_q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("sb_sig", 64'(res_sig), 64'(e[63:32]));
        chk("sb_count", 64'(res_count), 64'(e[31:0]));
      end
    end else if (!res_valid) seen = 1'b0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; resp_valid = 1'b0; res_ready = 1'b0;
    cfg_skip = '0; cfg_cycles = '0; resp_data = '0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_sig", 64'(res_sig), 64'd0);
    chk("rst_count", 64'(res_count), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    // Zero skip, zero cycles: DONE immediately with the seed.
    exp_q.push_back({32'hFFFFFFFF, 32'd0});
    go(8'd0, 32'd0);
    @(negedge clk);
    chk("t1_valid", 64'(res_valid), 64'd1);
    accept("t1");
    // Skip two, compact one zero beat.
    exp_q.push_back({32'hFB3EE249, 32'd1});
    go(8'd2, 32'd1);
    beat('0, 1'b0);
    beat('0, 1'b0);
    @(negedge clk);
    chk("t2_valid_before", 64'(res_valid), 64'd0);
    chk("t2_sig_untouched", 64'(res_sig), 64'hFFFFFFFF);
    beat('0, 1'b0);
    @(negedge clk);
    chk("t2_valid_after_beat3", 64'(res_valid), 64'd1);
    accept("t2");
    // Fold: bits 0 and 32 cancel.
    exp_q.push_back({32'hFB3EE249, 32'd1});
    go(8'd0, 32'd1);
    d = '0; d[0] = 1'b1; d[32] = 1'b1;
    beat(d, 1'b0);
    accept("t3");
    // Fold: bit 320 lands in the partial final word.
    exp_q.push_back({32'hFB3EE248, 32'd1});
    go(8'd0, 32'd1);
    d = '0; d[320] = 1'b1;
    beat(d, 1'b0);
    accept("t4");
    // DONE hold with res_ready low and start pulsing.
    exp_q.push_back({32'hF2BCD925, 32'd2});
    go(8'd0, 32'd2);
    beat('0, 1'b0);
    beat('0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      start = (i % 2) == 0;
      cfg_skip = 8'd3;
      cfg_cycles = 32'd7;
      @(negedge clk);
      chk("t5_hold_valid", 64'(res_valid), 64'd1);
      chk("t5_hold_sig", 64'(res_sig), 64'hF2BCD925);
      chk("t5_hold_count", 64'(res_count), 64'd2);
      tick();
    end
    start = 1'b0;
    accept("t5");
    tick();
    chk("t5_start_ignored", 64'(busy), 64'd0);
    // Abort on beat 4 of 10.
    go(8'd0, 32'd10);
    beat('0, 1'b0);
    beat('0, 1'b0);
    beat('0, 1'b0);
    beat('0, 1'b1);
    @(negedge clk);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_count", 64'(res_count), 64'd3);
    chk("t6_sig", 64'(res_sig), 64'hE1B8AFFD);
    chk("t6_valid", 64'(res_valid), 64'd0);
    repeat (4) tick();
    // Reset in the middle of RUN.
    go(8'd0, 32'd5);
    beat('0, 1'b0);
    beat('0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_valid", 64'(res_valid), 64'd0);
    chk("t7_sig", 64'(res_sig), 64'd0);
    chk("t7_count", 64'(res_count), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("t7_idle_after", 64'(busy), 64'd0);
    // Recovery run after reset.
    exp_q.push_back({32'hFB3EE249, 32'd1});
    go(8'd1, 32'd1);
    beat('0, 1'b0);
    beat('0, 1'b0);
    accept("t8");
    repeat (2) tick();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/resp_signature.md
RESP_SIGNATURE -- requirements
Module: resp_signature

Interface
REQ-001 SHALL have parameter OUT_W, default 330, meaning width of the DUT response word being compacted.
REQ-002 SHALL have parameter CYC_W, default 32, meaning width of the beat counter and of cfg_cycles.
REQ-003 SHALL have parameter SEED, default 32'hFFFFFFFF, meaning the signature value loaded on start.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, a pulse that begins a capture run; honoured only in IDLE.
REQ-007 SHALL have port abort, input, 1, which cancels the run from any state.
REQ-008 SHALL have port cfg_skip, input, 8, the number of leading valid beats to discard; sampled on start.
REQ-009 SHALL have port cfg_cycles, input, CYC_W, the number of beats to compact; sampled on start.
REQ-010 SHALL have port resp_valid, input, 1, which qualifies resp_data this cycle (one beat).
REQ-011 SHALL have port resp_data, input, OUT_W, the DUT response word.
REQ-012 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-013 SHALL have port res_valid, output, 1, result available; high only in DONE.
REQ-014 SHALL have port res_ready, input, 1, the consumer's acceptance of the result.
REQ-015 SHALL have port res_sig, output, 32, the current signature register.
REQ-016 SHALL have port res_count, output, CYC_W, the number of beats compacted.

Function
REQ-017 SHALL implement states IDLE, SKIP, RUN and DONE.
REQ-018 SHALL handle start in IDLE as follows: load sig to SEED and count to 0, and latch cfg_skip and cfg_cycles.
  - Next state is SKIP if cfg_skip!=0.
  - Otherwise next state is RUN if cfg_cycles!=0.
  - Otherwise next state is DONE.
REQ-019 SHALL ignore start in SKIP, RUN and DONE.
REQ-020 SHALL, in SKIP, decrement the skip counter on each resp_valid beat without touching sig; the beat that reaches 0 moves to RUN, or to DONE if cfg_cycles==0.
REQ-021 SHALL fold resp_data into 32 bits as the XOR of its 32-bit words, word k = bits [32k+31:32k]; the final partial word is zero-extended (330 bits gives 10 full words plus 10 bits).
REQ-022 SHALL, in RUN, on each resp_valid beat:
  - set sig <= ((sig<<1) ^ (sig[31] ? 32'h04C11DB7 : 0)) ^ fold;
  - set count <= count+1.
REQ-023 SHALL go to DONE on the RUN beat where count+1==cfg_cycles, so res_valid rises the cycle after the last beat's edge.
REQ-024 SHALL ignore resp_valid outside SKIP and RUN.
REQ-025 SHALL hold res_valid, res_sig and res_count stable in DONE until res_valid&&res_ready; on that handshake it returns to IDLE and res_valid falls the next cycle.
REQ-026 SHALL, on abort in any state, go to IDLE at the next edge with no result, leaving sig and count unchanged.
REQ-027 SHALL give abort priority over a simultaneous beat, start or res_ready.
REQ-028 SHALL let count never exceed cfg_cycles; no wrap handling is required.
REQ-029 SHALL show the live sig register on res_sig and the live count on res_count in every state.

Reset
REQ-030 SHALL, while rst_n is low, immediately force state IDLE, busy=0, res_valid=0, res_sig=0, res_count=0 and the skip counter to 0.
REQ-031 SHALL abandon a run in progress when reset is asserted mid-run; after release it waits in IDLE for a new start.

Verification
REQ-032 Bench SHALL check: start with cfg_skip=0, cfg_cycles=0 -> DONE next cycle; res_sig=FFFFFFFF, res_count=0.
REQ-033 Bench SHALL check: cfg_skip=2, cfg_cycles=1, three all-zero beats -> res_sig=FB3EE249, res_count=1, res_valid the cycle after beat 3.
REQ-034 Bench SHALL check the fold with cfg_cycles=1:
  - one beat with bits 0 and 32 set -> res_sig=FB3EE249;
  - one beat with bit 320 set -> res_sig=FB3EE248.
REQ-035 Bench SHALL check: in DONE, hold res_ready low for 5 cycles while pulsing start -> res_valid stays high, outputs stay stable, start is ignored; then raise res_ready -> IDLE, busy=0 next cycle.
REQ-036 Bench SHALL check: cfg_cycles=10, abort asserted on beat 4 together with resp_valid -> IDLE next cycle, res_count=3, res_valid never asserted.
REQ-037 Bench SHALL check: rst_n low during RUN -> busy, res_valid, res_sig and res_count are 0 before the next clock edge.
